// File: rtl/tcdm_prio_ctrl.sv
// Priority-vector and starvation controller for an ExtPrio TCDM butterfly network.
// Define TCDM_PRIO_CTRL_BOOST_EN to add wait counters and boost masking; otherwise only the stride counter exists.
module tcdm_prio_ctrl #(
  parameter int unsigned NumIn        = 32,
  parameter int unsigned NumOut       = 32,
  parameter int unsigned RrStride     = 5,
  parameter int unsigned StarveThresh = 8,
  localparam int unsigned AddWidth    = $clog2(NumOut)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumIn-1:0]    req_i,
  output logic [NumIn-1:0]    gnt_o,
  output logic [NumIn-1:0]    req_o,
  input  logic [NumIn-1:0]    gnt_i,
  output logic [AddWidth-1:0] rr_o,
  output logic                boost_active_o,
  output logic [NumIn-1:0]    boost_vec_o
);

  if ((RrStride % 2 == 0) || (RrStride >= NumOut) || (NumOut & (NumOut - 1)) != 0
      || (NumIn & (NumIn - 1)) != 0 || NumOut < NumIn || StarveThresh < 1) begin : g_bad_param
    $error("tcdm_prio_ctrl: illegal parameter combination");
  end

  logic [AddWidth-1:0] rr_q, rr_d;

  // NumOut is a power of two, so natural wrap of the counter is the modulo.
  assign rr_d  = (|gnt_i) ? rr_q + AddWidth'(RrStride) : rr_q;
  assign rr_o  = rr_q;
  assign gnt_o = gnt_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

`ifdef TCDM_PRIO_CTRL_BOOST_EN
  localparam int unsigned CntWidth = $clog2(StarveThresh + 1);

  typedef enum logic {StNormal, StBoost} state_e;

  state_e             state_q, state_d;
  logic [NumIn-1:0]   boost_q, boost_d, starved;
  logic [CntWidth-1:0] cnt_q [NumIn];
  logic [CntWidth-1:0] cnt_d [NumIn];

  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      starved[i] = (cnt_q[i] >= CntWidth'(StarveThresh)) && req_i[i];
    end
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    boost_d = '0;
    req_o   = req_i;
    unique case (state_q)
      StNormal: begin
        if (|starved) begin
          boost_d = starved;
          state_d = StBoost;
        end
      end
      StBoost: begin
        req_o   = req_i & boost_q;
        boost_d = boost_q & req_i & ~gnt_i;
        if (boost_d == '0) state_d = StNormal;
      end
      default: state_d = StNormal;
    endcase
  end

  // Masked masters hold their count so they re-enter arbitration with their history intact.
  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!req_i[i] || gnt_i[i]) begin
        cnt_d[i] = '0;
      end else if (req_o[i] && (cnt_q[i] < CntWidth'(StarveThresh))) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // NOTE: the wait counters are control state, not storage, so each entry is reset explicitly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StNormal;
      boost_q <= '0;
      for (int i = 0; i < NumIn; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      boost_q <= boost_d;
      cnt_q   <= cnt_d;
    end
  end

  assign boost_active_o = (state_q == StBoost);
  assign boost_vec_o    = boost_q;
`else
  assign req_o          = req_i;
  assign boost_active_o = 1'b0;
  assign boost_vec_o    = '0;
`endif

endmodule
